score_display: RTL and testbench
================================

# score_display

Parametrised multi-digit decimal display driver for the DE1-SoC seven-segment bank. It accepts a binary score or count through a load handshake and converts it to BCD with a sequential shift-add-3 (double-dabble) engine. It then drives DIGITS active-low seven-segment outputs, with overflow dashes, optional leading-zero blanking and blink mode. It sits between game logic (score/length counters) and the HEX outputs, and replaces per-digit combinational decoding.

## Interface
- DIGITS, 2: number of decimal digits driven (1..6).
- WIDTH, 8: width of the binary input value (1..20).
- BLINK_DIV, 25000000: clock cycles per blink half-period (≥1).

- clk  input  1  system clock; all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- value  input  WIDTH  unsigned binary value, sampled only on an accepted load.
- load  input  1  request conversion of value; accepted only when busy=0.
- blank_lz  input  1  1 = leading zeros blanked (digit 0 always shown).
- blink  input  1  1 = whole display blinks at BLINK_DIV rate.
- busy  output  1  conversion in progress; load ignored while high.
- done  output  1  one-cycle pulse when new digits are committed.
- overflow  output  1  last committed value ≥ 10^DIGITS.
- hex  output  7*DIGITS  segments, active-low, bit order g..a per digit; digit i (units = 0) at hex[7i+6:7i].

## Operation
- The FSM has three states: IDLE, CONV and COMMIT.
- **IDLE**: when load=1, the block captures value into a shift register and clears the DIGITS×4 BCD accumulator and the step counter. It also registers ovf_pend = (value ≥ 10^DIGITS), computed at full width so that no truncation occurs; if 2^WIDTH ≤ 10^DIGITS, ovf_pend is constant 0. The FSM then goes to CONV.
- **CONV**: each cycle, add 3 to every BCD nibble ≥5, then shift {bcd, shreg} left by 1. The counter runs 0..WIDTH-1. After step WIDTH-1 the FSM goes to COMMIT.
- **COMMIT**: copy the BCD accumulator to the digit store and ovf_pend to overflow, pulse done, and go to IDLE.
- On overflow, the digit store is ignored for display and the bench sees the accumulator's truncated value only internally.
- **Display stage (every cycle, registered into hex)**:
  - overflow=1: all digits show dash, 7'b0111111.
  - Otherwise, digit d is decoded: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Any nibble >9 shows 7'b1111111.
  - blank_lz=1: digit i>0 shows 7'b1111111 when it and all higher digits are 0.
  - blink=1 and blink phase=1: all digits show 7'b1111111, overriding everything else.
- **Blink counter**: free-running from reset, counts 0..BLINK_DIV-1. The phase toggles on wrap. blink only masks the output; it does not reset the counter.

## Timing
- Reset (asynchronous assert) sets: state=IDLE, busy=0, done=0, overflow=0, digit store=0, blink counter=0, phase=0, hex all 7'b1111111. The first edge after release drives hex from the stored 0.
- If load is accepted at edge k:
  - busy=1 from after edge k through edge k+WIDTH+1.
  - done=1 for exactly the cycle after edge k+WIDTH+1, and busy=0 in that same cycle.
  - hex reflects the new value after edge k+WIDTH+2.
- load while busy=1 is dropped entirely, with no queueing.
- load high in the done cycle is accepted, because busy=0. Back-to-back throughput is one conversion per WIDTH+2 cycles.
- value is sampled only at the accepting edge. Later changes do not affect the conversion in progress.
- blank_lz and blink take effect at the next edge (one-cycle registered latency).
- Reset asserted mid-conversion aborts the conversion. No done pulse is produced, and the digit store returns to 0.

## Test plan
- DIGITS=2, WIDTH=8, load value=42 -> done at edge k+9; then hex[6:0]=0100100 and hex[13:7]=0011001; overflow=0.
- load value=150 -> overflow=1, and both digits show 0111111. A following load of 99 -> overflow=0 and both digits show 0010000.
- load value=7 with blank_lz=1 -> hex[13:7]=1111111 and hex[6:0]=1111000. With blank_lz=0, hex[13:7]=1000000. Load value=0 with blank_lz=1 -> units digit shows 1000000.
- load value=42, then load value=17 at edge k+3 (busy) -> the second load is ignored, a single done pulse occurs, and 42 is displayed.
- BLINK_DIV=4, blink=1, value 42 committed -> hex alternates between the 42 pattern and all-1111111 every 4 cycles. Setting blink=0 restores steady display on the next edge.
- Assert reset_n=0 at edge k+4 of a conversion of 55 -> busy=0, done=0, and hex=all 1111111 immediately. After release, hex shows 1000000 (plus 1000000 in the tens digit with blank_lz=0), and no done pulse occurs.

Source files
------------

// File: rtl/score_display.sv
// Binary-to-decimal seven-segment driver: sequential double-dabble conversion behind a load
// handshake, with overflow dashes, leading-zero blanking and blink masking on the HEX outputs.
module score_display #(
    parameter int unsigned DIGITS    = 2,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned BLINK_DIV = 25000000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [WIDTH-1:0]      value,
    input  logic                  load,
    input  logic                  blank_lz,
    input  logic                  blink,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [7*DIGITS-1:0]   hex
);

    function automatic int unsigned pow10(input int unsigned n);
        int unsigned p;
        p = 1;
        for (int unsigned i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    localparam int unsigned LIMIT = pow10(DIGITS);
    // When every WIDTH-bit value fits in DIGITS digits the overflow flag can never set.
    localparam bit OVF_POSSIBLE = (64'd1 << WIDTH) > 64'(LIMIT);
    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned BW = $clog2(BLINK_DIV + 1);
    localparam int unsigned BCDW = 4 * DIGITS;

    typedef enum logic [1:0] {StIdle, StConv, StCommit} state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    shreg_q, shreg_d;
    logic [BCDW-1:0]     bcd_q, bcd_d, bcd_adj;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                ovf_pend_q, ovf_pend_d;
    logic [BCDW-1:0]     digits_q, digits_d;
    logic                overflow_q, overflow_d;
    logic                done_q, done_d;
    logic [7*DIGITS-1:0] hex_q, hex_d;
    logic [BW-1:0]       bcnt_q, bcnt_d;
    logic                phase_q, phase_d;
    logic [31:0]         value_ext;
    logic                nonzero_above;
    logic [3:0]          nib;
    logic [6:0]          seg;

    assign value_ext = 32'(value);

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        digits_d   = digits_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (load) begin
                    shreg_d    = value;
                    bcd_d      = '0;
                    cnt_d      = '0;
                    ovf_pend_d = OVF_POSSIBLE && (value_ext >= LIMIT);
                    state_d    = StConv;
                end
            end
            StConv: begin
                {bcd_d, shreg_d} = {bcd_adj[BCDW-2:0], shreg_q, 1'b0};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = StCommit;
                end
            end
            StCommit: begin
                digits_d   = bcd_q;
                overflow_d = ovf_pend_q;
                done_d     = 1'b1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        if (bcnt_q == BW'(BLINK_DIV - 1)) begin
            bcnt_d  = '0;
            phase_d = ~phase_q;
        end else begin
            bcnt_d  = bcnt_q + BW'(1);
            phase_d = phase_q;
        end
    end

    // Walk from the most significant digit so leading-zero status is known per digit.
    always_comb begin
        hex_d         = '1;
        nonzero_above = 1'b0;
        nib           = '0;
        seg           = '1;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            nib           = digits_q[4*i +: 4];
            nonzero_above = nonzero_above | (nib != 4'd0);
            seg           = seg_decode(nib);
            if (blank_lz && (i > 0) && !nonzero_above) begin
                seg = 7'b1111111;
            end
            if (overflow_q) begin
                seg = 7'b0111111;
            end
            if (blink && phase_q) begin
                seg = 7'b1111111;
            end
            hex_d[7*i +: 7] = seg;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            shreg_q    <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            digits_q   <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
            hex_q      <= '1;
            bcnt_q     <= '0;
            phase_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            digits_q   <= digits_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
            hex_q      <= hex_d;
            bcnt_q     <= bcnt_d;
            phase_q    <= phase_d;
        end
    end

    assign busy     = (state_q != StIdle);
    assign done     = done_q;
    assign overflow = overflow_q;
    assign hex      = hex_q;

endmodule

// File: tb/tb_score_display.sv
// Bench for score_display: directed scenarios plus random loads checked against an
// arithmetic decimal-display model.
module tb_score_display;

    localparam int unsigned DIGITS    = 2;
    localparam int unsigned WIDTH     = 8;
    localparam int unsigned BLINK_DIV = 4;
    localparam int          LIMIT     = 100;
    localparam int          HW        = 7 * DIGITS;

    logic             clk;
    logic             reset_n;
    logic [WIDTH-1:0] value;
    logic             load;
    logic             blank_lz;
    logic             blink;
    logic             busy;
    logic             done;
    logic             overflow;
    logic [HW-1:0]    hex;

    int total = 0;
    int bad   = 0;
    int shown = 0;
    int ecount;

    score_display #(
        .DIGITS    (DIGITS),
        .WIDTH     (WIDTH),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .value    (value),
        .load     (load),
        .blank_lz (blank_lz),
        .blink    (blink),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .hex      (hex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges since reset release; drives the blink-phase expectation.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) ecount <= 0;
        else          ecount <= ecount + 1;
    end

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [HW-1:0] exp_hex(input int v, input bit blz);
        logic [HW-1:0] h;
        int p;
        h = '1;
        p = 1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (v >= LIMIT)                h[7*i +: 7] = 7'b0111111;
            else if (blz && i > 0 && v < p) h[7*i +: 7] = 7'b1111111;
            else                           h[7*i +: 7] = seg_of((v / p) % 10);
            p = p * 10;
        end
        return h;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Caller drives load=1/value=v; the next rising edge is the accepting edge k.
    task automatic conv(input int v, input bit intrude, input bit chain, input int nv);
        @(negedge clk);
        check("hex_hold", 32'(hex), 32'(exp_hex(shown, blank_lz)));
        check("busy_acc", 32'(busy), 32'd1);
        load  = 1'b0;
        value = WIDTH'($urandom);
        for (int j = 1; j <= int'(WIDTH) + 1; j++) begin
            if (intrude && j == 3) begin
                load  = 1'b1;
                value = WIDTH'($urandom_range(0, 255));
            end else begin
                load = 1'b0;
            end
            @(negedge clk);
            check("busy", 32'(busy), 32'(j <= int'(WIDTH)));
            check("done", 32'(done), 32'(j == int'(WIDTH) + 1));
        end
        shown = v;
        check("ovf", 32'(overflow), 32'(v >= LIMIT));
        if (chain) begin
            load  = 1'b1;
            value = WIDTH'(nv);
        end else begin
            load = 1'b0;
            @(negedge clk);
            check("hex_new", 32'(hex), 32'(exp_hex(shown, blank_lz)));
            check("done_clr", 32'(done), 32'd0);
        end
    endtask

    task automatic start(input int v, input bit blz);
        @(negedge clk);
        blank_lz = blz;
        value    = WIDTH'(v);
        load     = 1'b1;
    endtask

    initial begin
        int v;
        bit blz;
        reset_n  = 1'b1;
        value    = '0;
        load     = 1'b0;
        blank_lz = 1'b0;
        blink    = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("rst_hex", 32'(hex), 32'h3fff);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("first_hex", 32'(hex), 32'(exp_hex(0, 1'b0)));

        // 42 and explicit segment patterns
        start(42, 1'b0);
        conv(42, 1'b0, 1'b0, 0);
        check("h42_units", 32'(hex[6:0]), 32'(7'b0100100));
        check("h42_tens", 32'(hex[13:7]), 32'(7'b0011001));

        // overflow then recovery
        start(150, 1'b0);
        conv(150, 1'b0, 1'b0, 0);
        check("h150", 32'(hex), 32'({7'b0111111, 7'b0111111}));
        start(99, 1'b0);
        conv(99, 1'b0, 1'b0, 0);
        check("h99", 32'(hex), 32'({7'b0010000, 7'b0010000}));

        // leading-zero blanking
        start(7, 1'b1);
        conv(7, 1'b0, 1'b0, 0);
        check("h7_blz", 32'(hex), 32'({7'b1111111, 7'b1111000}));
        @(negedge clk);
        blank_lz = 1'b0;
        @(negedge clk);
        check("h7_noblz", 32'(hex[13:7]), 32'(7'b1000000));
        start(0, 1'b1);
        conv(0, 1'b0, 1'b0, 0);
        check("h0_blz", 32'(hex), 32'({7'b1111111, 7'b1000000}));

        // load while busy is dropped
        start(42, 1'b0);
        conv(42, 1'b1, 1'b0, 0);

        // load in the done cycle is accepted back to back
        start(63, 1'b0);
        conv(63, 1'b0, 1'b1, 128);
        conv(128, 1'b0, 1'b0, 0);

        // blink masking follows the free-running phase
        start(42, 1'b0);
        conv(42, 1'b0, 1'b0, 0);
        blink = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            check("blink", 32'(hex),
                  32'((((ecount - 1) / int'(BLINK_DIV)) % 2 == 1) ? {HW{1'b1}} :
                      exp_hex(42, 1'b0)));
        end
        blink = 1'b0;
        @(negedge clk);
        check("blink_off", 32'(hex), 32'(exp_hex(42, 1'b0)));

        // random loads
        for (int n = 0; n < 30; n++) begin
            v   = int'($urandom_range(0, 255));
            blz = 1'($urandom);
            start(v, blz);
            conv(v, ($urandom % 4) == 0, 1'b0, 0);
        end

        // reset mid-conversion
        start(55, 1'b0);
        @(negedge clk);
        load = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_hex", 32'(hex), 32'h3fff);
        @(negedge clk);
        reset_n = 1'b1;
        shown   = 0;
        @(negedge clk);
        check("abort_hex0", 32'(hex), 32'(exp_hex(0, 1'b0)));
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check("abort_nodone", 32'(done), 32'd0);
            check("abort_idle", 32'(busy), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
